// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: instruction fetch and data ports
// share one memory bus, data preferred, fetch protected from starvation.
module mem_port_arbiter #(
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic        dm_byte,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_byte,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    state_t        state, state_n;
    logic [2:0]    starve_cnt, starve_cnt_n;
    logic [CW-1:0] busy_cnt, busy_cnt_n;

    logic          if_ack_n, dm_ack_n, err_n;
    logic [31:0]   if_rdata_n, dm_rdata_n;
    logic          mem_req_n, mem_we_n, mem_byte_n;
    logic [31:0]   mem_addr_n, mem_wdata_n;

    logic          starve_full, grant_d, grant_i, timeout_hit;

    assign starve_full = (starve_cnt == 3'(STARVE_LIMIT));
    assign grant_d     = dm_req && !(if_req && starve_full);
    assign grant_i     = if_req && !grant_d;
    assign timeout_hit = (busy_cnt == CW'(TIMEOUT));

    // State and registered outputs; reset clears everything and aborts any access
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            busy_cnt   <= '0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            err        <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_byte   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_cnt_n;
            busy_cnt   <= busy_cnt_n;
            if_ack     <= if_ack_n;
            dm_ack     <= dm_ack_n;
            err        <= err_n;
            if_rdata   <= if_rdata_n;
            dm_rdata   <= dm_rdata_n;
            mem_req    <= mem_req_n;
            mem_we     <= mem_we_n;
            mem_byte   <= mem_byte_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
        end
    end

    // Next state: grant in IDLE, finish on ready or timeout, one RESP cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_n = BUSY_D;
                end else if (grant_i) begin
                    state_n = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready || timeout_hit) begin
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs, counters and request latches
    always_comb begin
        starve_cnt_n = starve_cnt;
        busy_cnt_n   = busy_cnt;
        if_ack_n     = 1'b0;
        dm_ack_n     = 1'b0;
        err_n        = err;
        if_rdata_n   = if_rdata;
        dm_rdata_n   = dm_rdata;
        mem_req_n    = mem_req;
        mem_we_n     = mem_we;
        mem_byte_n   = mem_byte;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        case (state)
            IDLE: begin
                err_n = 1'b0;
                if (grant_d) begin
                    mem_req_n   = 1'b1;
                    mem_we_n    = dm_we;
                    mem_byte_n  = dm_byte;
                    mem_addr_n  = dm_addr;
                    mem_wdata_n = dm_wdata;
                    busy_cnt_n  = CW'(1);
                    if (if_req && starve_cnt != 3'd7) begin
                        starve_cnt_n = starve_cnt + 3'd1;
                    end
                end else if (grant_i) begin
                    mem_req_n    = 1'b1;
                    mem_we_n     = 1'b0;
                    mem_byte_n   = 1'b0;
                    mem_addr_n   = if_addr;
                    mem_wdata_n  = '0;
                    busy_cnt_n   = CW'(1);
                    starve_cnt_n = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready || timeout_hit) begin
                    mem_req_n  = 1'b0;
                    mem_we_n   = 1'b0;
                    mem_byte_n = 1'b0;
                    err_n      = !mem_ready;
                    if (state == BUSY_I) begin
                        if_ack_n   = 1'b1;
                        if_rdata_n = mem_ready ? mem_rdata : '0;
                    end else begin
                        dm_ack_n = 1'b1;
                        if (!mem_ready) begin
                            dm_rdata_n = '0;
                        end else if (!mem_we) begin
                            dm_rdata_n = mem_rdata;
                        end
                    end
                end else begin
                    busy_cnt_n = busy_cnt + CW'(1);
                end
            end
            RESP: begin
                err_n = 1'b0;
            end
            default: begin
                err_n = 1'b0;
            end
        endcase
    end

endmodule
